// File: rtl/ioctl_region_loader.sv
// Routes one ioctl download index into address regions. It registers one-hot chip selects,
// region-relative word addresses and write strobes, and tracks per-region byte completion.
module ioctl_region_loader #(
    parameter int                          NUM_REGIONS = 12,
    parameter logic [7:0]                  INDEX       = 8'd0,
    parameter int                          DATA_W      = 8,
    parameter logic [NUM_REGIONS*25-1:0]   REGION_BASE = '0,
    parameter logic [NUM_REGIONS*25-1:0]   REGION_SIZE = {NUM_REGIONS{25'h1000}}
) (
    input  logic                   clk_49m,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_data,
    input  logic                   ioctl_wr,
    output logic [NUM_REGIONS-1:0] rom_cs,
    output logic [24:0]            rom_addr,
    output logic [DATA_W-1:0]      rom_data,
    output logic                   rom_wr,
    output logic [NUM_REGIONS-1:0] region_done,
    output logic                   all_done,
    output logic                   stray
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int SHIFT = (DATA_W == 16) ? 1 : 0;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                 state_q;
    logic                   dl_q;
    logic [NUM_REGIONS-1:0] cs_q, cs_d;
    logic [24:0]            addr_q, addr_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   wr_q, wr_d;
    logic [NUM_REGIONS-1:0] done_q, done_d;
    logic                   all_done_q;
    logic                   stray_q, stray_d;
    logic [7:0]             hold_q, hold_d, hold_eff;
    logic [IDX_W-1:0]       tag_q, tag_d;
    logic [24:0]            cnt_q [NUM_REGIONS];
    logic [24:0]            cnt_d [NUM_REGIONS];

    logic                   index_ok, accepted, rise;
    logic [NUM_REGIONS-1:0] hit_vec, onehot;
    logic                   any_hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [24:0]            hit_base, offset;
    logic                   odd;

    assign index_ok = (ioctl_index == INDEX);
    assign accepted = ioctl_wr && index_ok;
    assign rise     = ioctl_download && !dl_q && index_ok;

    // Range compare in 26 bits so base+size never wraps.
    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hit_vec[i] = ({1'b0, ioctl_addr} >= {1'b0, REGION_BASE[25*i +: 25]}) &&
                         ({1'b0, ioctl_addr} <  ({1'b0, REGION_BASE[25*i +: 25]} +
                                                 {1'b0, REGION_SIZE[25*i +: 25]}));
        end
    end

    // Scanning downward leaves the lowest overlapping index as the winner.
    always_comb begin
        any_hit  = 1'b0;
        hit_idx  = '0;
        hit_base = '0;
        onehot   = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit   = 1'b1;
                hit_idx   = IDX_W'(i);
                hit_base  = REGION_BASE[25*i +: 25];
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign offset   = ioctl_addr - hit_base;
    assign odd      = offset[0];
    assign hold_eff = (rise || (tag_q != hit_idx)) ? 8'h00 : hold_q;

    generate
        if (DATA_W == 16) begin : g_w16
            assign data_d = {ioctl_data, hold_eff};
        end else begin : g_w8
            logic [7:0] unused_hold;
            assign unused_hold = hold_eff;
            assign data_d      = ioctl_data;
        end
    endgenerate

    always_comb begin
        wr_d    = accepted && any_hit && ((DATA_W == 8) || odd);
        cs_d    = wr_d ? onehot : '0;
        addr_d  = offset >> SHIFT;
        stray_d = rise ? 1'b0 : stray_q;
        if (accepted && !any_hit) stray_d = 1'b1;
        hold_d  = rise ? 8'h00 : hold_q;
        tag_d   = tag_q;
        if (accepted && any_hit && (DATA_W == 16)) begin
            if (!odd) begin
                hold_d = ioctl_data;
                tag_d  = hit_idx;
            end else begin
                hold_d = 8'h00;
            end
        end
    end

    // A download edge clears the counters before the same-cycle byte is counted.
    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            cnt_d[i] = rise ? 25'd0 : cnt_q[i];
            if (accepted && onehot[i] && (cnt_d[i] != REGION_SIZE[25*i +: 25]))
                cnt_d[i] = cnt_d[i] + 25'd1;
            done_d[i] = (cnt_d[i] == REGION_SIZE[25*i +: 25]);
        end
    end

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dl_q       <= 1'b0;
            cs_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            done_q     <= '0;
            all_done_q <= 1'b0;
            stray_q    <= 1'b0;
            hold_q     <= 8'h00;
            tag_q      <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) cnt_q[i] <= '0;
        end else begin
            dl_q <= ioctl_download;
            case (state_q)
                S_IDLE:   if (rise) state_q <= S_ACTIVE;
                S_ACTIVE: if (!ioctl_download) state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            if (wr_d) begin
                addr_q <= addr_d;
                data_q <= data_d;
            end
            done_q     <= done_d;
            all_done_q <= &done_d;
            stray_q    <= stray_d;
            hold_q     <= hold_d;
            tag_q      <= tag_d;
            for (int i = 0; i < NUM_REGIONS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rom_cs      = cs_q;
    assign rom_addr    = addr_q;
    assign rom_data    = data_q;
    assign rom_wr      = wr_q;
    assign region_done = done_q;
    assign all_done    = all_done_q;
    assign stray       = stray_q;

endmodule
